fib_seq_gen: RTL and testbench

Parametrised Fibonacci-style sequence generator with configurable width, programmable seeds and term count.
- Emits terms one per accepted transfer on a valid/ready output stream.
- Flags arithmetic wrap and signals completion.
- Sits as a stimulus/data source feeding downstream lab datapath blocks.
- Replaces the fixed 4-bit free-running generator with a controllable, back-pressurable source.

---
 rtl/fib_seq_gen.sv | 127 ++++++++++++
 tb/tb_fib_seq_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// Fibonacci-style term source on a valid/ready stream with programmable seeds and length.
// Define FIB_SAT_EN to saturate terms at all-ones instead of wrapping modulo 2^WIDTH.
module fib_seq_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             out_wrap,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic             prev_wrap;
    logic             cur_wrap;
    logic [CNT_W-1:0] index;
    logic [CNT_W-1:0] n_lat;
    logic             handshake;
    logic             last;
    logic [WIDTH:0]   next_sum;

    // Returns {wrap, term}; the wrap flag is sticky along the sequence so a
    // term built from an already-wrapped operand is also reported as wrapped.
    function automatic logic [WIDTH:0] next_term(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic wrap_in);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef FIB_SAT_EN
        if (sum[WIDTH] | wrap_in)
            return {1'b1, {WIDTH{1'b1}}};
        return sum;
`else
        return {sum[WIDTH] | wrap_in, sum[WIDTH-1:0]};
`endif
    endfunction

    assign handshake = out_valid & out_ready;
    assign last      = (index == n_lat - CNT_W'(1));
    assign next_sum  = next_term(prev, cur, prev_wrap | cur_wrap);

    // Term outputs read as zero whenever no term is being offered.
    assign out_data  = out_valid ? prev : '0;
    assign out_index = out_valid ? index : '0;
    assign out_wrap  = out_valid & prev_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev      <= '0;
            cur       <= '0;
            prev_wrap <= 1'b0;
            cur_wrap  <= 1'b0;
            index     <= '0;
            n_lat     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        prev      <= seed0;
                        cur       <= seed1;
                        prev_wrap <= 1'b0;
                        cur_wrap  <= 1'b0;
                        index     <= '0;
                        n_lat     <= n_terms;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        if (n_terms != '0) begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Everything holds while the consumer stalls.
                    if (handshake) begin
                        prev      <= cur;
                        prev_wrap <= cur_wrap;
                        cur       <= next_sum[WIDTH-1:0];
                        cur_wrap  <= next_sum[WIDTH];
                        index     <= index + CNT_W'(1);
                        overflow  <= overflow | prev_wrap;
                        if (last) begin
                            state     <= FIN;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: a 16-bit instance for sequencing/handshake
// and an 8-bit instance for wrap/saturation (FIB_SAT_EN selects expectations).
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, out_ready;
    logic [7:0]  n_terms;
    logic [15:0] seed0, seed1;
    logic        out_valid, out_wrap, busy, done, overflow;
    logic [15:0] out_data;
    logic [7:0]  out_index;

    logic        start8, ready8;
    logic [7:0]  n8, s0_8, s1_8;
    logic        v8, w8, busy8, done8, ovf8;
    logic [7:0]  d8, i8;

    int errors = 0;
    int checks = 0;

`ifdef FIB_SAT_EN
    localparam logic [7:0] T14 = 8'd255;
`else
    localparam logic [7:0] T14 = 8'd121;
`endif

    logic [15:0] exp16 [10] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34};
    logic [7:0]  exp8  [15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                                8'd55, 8'd89, 8'd144, 8'd233, T14};

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(16), .CNT_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .seed0(seed0), .seed1(seed1), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .out_wrap(out_wrap), .busy(busy), .done(done), .overflow(overflow)
    );

    fib_seq_gen #(.WIDTH(8), .CNT_W(8)) u8w (
        .clk(clk), .rst_n(rst_n), .start(start8), .n_terms(n8),
        .seed0(s0_8), .seed1(s1_8), .out_ready(ready8),
        .out_valid(v8), .out_data(d8), .out_index(i8),
        .out_wrap(w8), .busy(busy8), .done(done8), .overflow(ovf8)
    );

    task automatic start16(input logic [7:0] n, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; n_terms = n; seed0 = a; seed1 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start8w(input logic [7:0] n);
        @(negedge clk);
        start8 = 1'b1; n8 = n; s0_8 = 8'd0; s1_8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic test_reset;
        bit done_seen;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({out_valid, busy, done, overflow, out_wrap} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {out_valid, busy, done, overflow, out_wrap}); end
        checks++; if (out_data !== 16'd0 || out_index !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", out_data, out_index); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, busy, done} !== 3'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 000", {out_valid, busy, done}); end
        out_ready = 1'b1;
        start16(8'd10, 16'd0, 16'd1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin errors++; $display("FAIL pre_abort: got v=%b d=%0d want v=1 d=1", out_valid, out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_async: got v=%b busy=%b want 0/0", out_valid, busy); end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1 if (done) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done_seen); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, busy, done, overflow, out_wrap} !== 5'b0 || out_data !== 16'd0 || out_index !== 8'd0) begin errors++; $display("FAIL idle_after_abort: got ctrl=%b d=%0d i=%0d want zeros", {out_valid, busy, done, overflow, out_wrap}, out_data, out_index); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        start16(8'd10, 16'd0, 16'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp16[i] || out_index !== 8'(i) || out_wrap !== 1'b0) begin errors++; $display("FAIL basic_term%0d: got v=%b d=%0d i=%0d w=%b want v=1 d=%0d i=%0d w=0", i, out_valid, out_data, out_index, out_wrap, exp16[i], i); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%b v=%b want 1/0", done, out_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL basic_end: got done=%b busy=%b ovf=%b want 000", done, busy, overflow); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        start16(8'd10, 16'd0, 16'd1);
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp16[i] || out_index !== 8'(i)) begin errors++; $display("FAIL bp_term%0d: got v=%b d=%0d i=%0d want d=%0d", i, out_valid, out_data, out_index, exp16[i]); end
            if (i == 5) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++; if (out_valid !== 1'b1 || out_data !== 16'd5 || out_index !== 8'd5) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d i=%0d want v=1 d=5 i=5", k, out_valid, out_data, out_index); end
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_start_busy;
        out_ready = 1'b1;
        start16(8'd6, 16'd0, 16'd1);
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp16[i]) begin errors++; $display("FAIL busy_term%0d: got v=%b d=%0d want d=%0d", i, out_valid, out_data, exp16[i]); end
            if (i == 2) begin
                start = 1'b1; seed0 = 16'd100; seed1 = 16'd50; n_terms = 8'd2;
            end
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", done); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fin_start_ignored: got v=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_wrap;
        ready8 = 1'b1;
        start8w(8'd15);
        for (int i = 0; i < 15; i++) begin
            checks++; if (v8 !== 1'b1 || d8 !== exp8[i] || w8 !== (i == 14)) begin errors++; $display("FAIL wrap_term%0d: got v=%b d=%0d w=%b want d=%0d w=%b", i, v8, d8, w8, exp8[i], (i == 14)); end
            @(negedge clk);
        end
        checks++; if (done8 !== 1'b1 || ovf8 !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got done=%b ovf=%b want 1/1", done8, ovf8); end
        start8w(8'd14);
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf8); end
        for (int i = 0; i < 14; i++) begin
            checks++; if (d8 !== exp8[i] || w8 !== 1'b0) begin errors++; $display("FAIL look_term%0d: got d=%0d w=%b want d=%0d w=0", i, d8, w8, exp8[i]); end
            @(negedge clk);
        end
        checks++; if (done8 !== 1'b1 || ovf8 !== 1'b0) begin errors++; $display("FAIL lookahead_ovf: got done=%b ovf=%b want 1/0", done8, ovf8); end
        @(negedge clk);
    endtask

    task automatic test_edge_counts;
        int done_cnt;
        int valid_cnt;
        done_cnt = 0; valid_cnt = 0;
        @(negedge clk);
        start = 1'b1; n_terms = 8'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL n0_done: got %0d pulses want 1", done_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL n0_valid: got %0d cycles want 0", valid_cnt); end
        out_ready = 1'b1;
        start16(8'd1, 16'd7, 16'd9);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd7 || out_index !== 8'd0) begin errors++; $display("FAIL n1_term: got v=%b d=%0d i=%0d want 1/7/0", out_valid, out_data, out_index); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL n1_done: got done=%b v=%b want 1/0", done, out_valid); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0; out_ready = 1'b0; n_terms = '0; seed0 = '0; seed1 = '0;
        start8 = 1'b0; ready8 = 1'b0; n8 = '0; s0_8 = '0; s1_8 = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_start_busy;
        test_wrap;
        test_edge_counts;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
